// File: rtl/seg_readback_pkg.sv
// Shared types and constants for the seven-segment readback path.
package seg_readback_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // Segment patterns in {a,b,c,d,e,f,g} order, a = MSB, active-high.
  localparam logic [6:0] SEG_P0 = 7'b1111110;
  localparam logic [6:0] SEG_P1 = 7'b0110000;
  localparam logic [6:0] SEG_P2 = 7'b1101101;
  localparam logic [6:0] SEG_P3 = 7'b1111001;
  localparam logic [6:0] SEG_PE = 7'b1001111;

  localparam logic [2:0] CODE_DEFAULT = 3'b100;
  localparam logic [2:0] CODE_ERR     = 3'b111;

endpackage

// File: rtl/seven_segment_pattern_lookup.sv
// Combinational decode of a 7-bit segment pattern back to its 3-bit code.
module seven_segment_pattern_lookup
  import seg_readback_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [2:0] code,
  output logic       is_default,
  output logic       code_err
);

  // Only five patterns are legal; everything else is flagged as an error.
  always_comb begin
    code       = CODE_ERR;
    is_default = 1'b0;
    code_err   = 1'b1;
    case (pattern)
      SEG_P0: begin code = 3'd0; code_err = 1'b0; end
      SEG_P1: begin code = 3'd1; code_err = 1'b0; end
      SEG_P2: begin code = 3'd2; code_err = 1'b0; end
      SEG_P3: begin code = 3'd3; code_err = 1'b0; end
      SEG_PE: begin code = CODE_DEFAULT; code_err = 1'b0; is_default = 1'b1; end
      default: begin code = CODE_ERR; code_err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seven_segment_readback.sv
// Glitch-filtered readback of the seven-segment lines: registers the pins,
// waits for a stable pattern, then reports its decoded code with a 1-cycle pulse.
module seven_segment_readback
  import seg_readback_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       seg_a,
  input  logic       seg_b,
  input  logic       seg_c,
  input  logic       seg_d,
  input  logic       seg_e,
  input  logic       seg_f,
  input  logic       seg_g,
  output logic [2:0] code,
  output logic       code_valid,
  output logic       code_err,
  output logic       is_default,
  output logic       busy
);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 7) begin : g_bad_stable_cycles
    $error("seven_segment_readback: STABLE_CYCLES must be within 2..7");
  end

  localparam logic [6:0] INV_MASK = ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic [2:0] CNT_LAST = 3'(STABLE_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [6:0] seg_q;
  logic [6:0] sample_reg, sample_next;
  logic [2:0] cnt_reg, cnt_next;
  logic       load_report;

  logic [2:0] lut_code;
  logic       lut_default;
  logic       lut_err;

  // Register the pins (normalised to active-high) so nothing combinational reaches the outputs.
  always_ff @(posedge clk) begin
    if (rst) seg_q <= '0;
    else     seg_q <= {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} ^ INV_MASK;
  end

  seven_segment_pattern_lookup u_lookup (
    .pattern    (sample_reg),
    .code       (lut_code),
    .is_default (lut_default),
    .code_err   (lut_err)
  );

  // State, captured pattern and stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      sample_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      sample_reg <= sample_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Next-state logic: any change of the registered pattern restarts the stability count.
  always_comb begin
    state_next  = state_reg;
    sample_next = sample_reg;
    cnt_next    = cnt_reg;
    load_report = 1'b0;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next  = SETTLE;
          sample_next = seg_q;
          cnt_next    = '0;
        end
        SETTLE: begin
          if (seg_q != sample_reg) begin
            sample_next = seg_q;
            cnt_next    = '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_next  = REPORT;
            load_report = 1'b1;
          end else if (cnt_reg != 3'd7) begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
        REPORT: begin
          state_next = HOLD;
        end
        HOLD: begin
          if (seg_q != sample_reg) begin
            state_next  = SETTLE;
            sample_next = seg_q;
            cnt_next    = '0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output registers: code fields hold between reports, valid is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      code       <= '0;
      code_valid <= 1'b0;
      code_err   <= 1'b0;
      is_default <= 1'b0;
    end else begin
      code_valid <= load_report;
      if (load_report) begin
        code       <= lut_code;
        code_err   <= lut_err;
        is_default <= lut_default;
      end
    end
  end

  assign busy = (state_reg == SETTLE) || (state_reg == REPORT);

endmodule

// File: tb/tb_seven_segment_readback.sv
// Self-checking bench for seven_segment_readback: directed vectors plus randomized
// stimulus compared every cycle against a behavioural model.
module tb_seven_segment_readback;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [6:0] pins = 7'd0;
  logic [6:0] pins_al = 7'd0;

  logic [2:0] code, al_code;
  logic       code_valid, code_err, is_default, busy;
  logic       al_valid, al_err, al_default, al_busy;

  int checks = 0;
  int errors = 0;
  int al_pulses = 0;

  always #5 clk = ~clk;

  seven_segment_readback #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en),
    .seg_a(pins[6]), .seg_b(pins[5]), .seg_c(pins[4]), .seg_d(pins[3]),
    .seg_e(pins[2]), .seg_f(pins[1]), .seg_g(pins[0]),
    .code(code), .code_valid(code_valid), .code_err(code_err),
    .is_default(is_default), .busy(busy)
  );

  seven_segment_readback #(.STABLE_CYCLES(S), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .en(en),
    .seg_a(pins_al[6]), .seg_b(pins_al[5]), .seg_c(pins_al[4]), .seg_d(pins_al[3]),
    .seg_e(pins_al[2]), .seg_f(pins_al[1]), .seg_g(pins_al[0]),
    .code(al_code), .code_valid(al_valid), .code_err(al_err),
    .is_default(al_default), .busy(al_busy)
  );

  // Legal display patterns, indexed by the digit they show (index 4 = "E").
  logic [6:0] legal [5] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b1001111};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input logic [6:0] p, output int c, output int e, output int d);
    c = 7; e = 1; d = 0;
    for (int i = 0; i < 5; i++) begin
      if (p == legal[i]) begin
        c = i; e = 0; d = (i == 4) ? 1 : 0;
      end
    end
  endfunction

  // Behavioural model: watches the registered pattern, reports once it has matched
  // the reference for S edges, then stays quiet until the pattern moves.
  logic [6:0] m_q = '0, m_ref = '0;
  int m_age = 0;
  bit m_on = 0, m_watch = 0, m_blind = 0;
  int m_code = 0, m_err = 0, m_def = 0, m_valid = 0;

  always @(posedge clk) begin
    int c, e, d;
    if (rst) begin
      m_on = 0; m_watch = 0; m_blind = 0; m_age = 0; m_ref = '0;
      m_code = 0; m_err = 0; m_def = 0; m_valid = 0;
    end else if (!en) begin
      m_on = 0; m_watch = 0; m_blind = 0; m_valid = 0;
    end else if (!m_on) begin
      m_on = 1; m_watch = 1; m_ref = m_q; m_age = 0; m_valid = 0;
    end else if (m_blind) begin
      m_blind = 0; m_valid = 0;
    end else if (m_q != m_ref) begin
      m_ref = m_q; m_age = 0; m_watch = 1; m_valid = 0;
    end else if (m_watch && m_age == S - 1) begin
      ref_decode(m_ref, c, e, d);
      m_code = c; m_err = e; m_def = d; m_valid = 1;
      m_watch = 0; m_blind = 1;
    end else begin
      if (m_watch) m_age = m_age + 1;
      m_valid = 0;
    end
    m_q = rst ? 7'd0 : pins;
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cyc_code", int'(code), m_code);
    check("cyc_valid", int'(code_valid), m_valid);
    check("cyc_err", int'(code_err), m_err);
    check("cyc_default", int'(is_default), m_def);
    check("cyc_busy", int'(busy), int'(m_on && (m_watch || m_blind)));
    if (al_valid) al_pulses++;
  end

  typedef struct {
    logic [6:0] pattern;
    int         pulses;
    int         exp_code;
    int         exp_err;
    int         exp_def;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int pulses;
    bit seen;
    int hold_left;

    // Loopback of the display driver: inp 0..7, then illegal and extra legal patterns.
    vecs[0]  = '{7'b1111110, 1, 0, 0, 0};
    vecs[1]  = '{7'b0110000, 1, 1, 0, 0};
    vecs[2]  = '{7'b1101101, 1, 2, 0, 0};
    vecs[3]  = '{7'b1111001, 1, 3, 0, 0};
    vecs[4]  = '{7'b1001111, 1, 4, 0, 1};
    vecs[5]  = '{7'b1001111, 0, 4, 0, 1};
    vecs[6]  = '{7'b1001111, 0, 4, 0, 1};
    vecs[7]  = '{7'b1001111, 0, 4, 0, 1};
    vecs[8]  = '{7'b0000001, 1, 7, 1, 0};
    vecs[9]  = '{7'b0000000, 1, 7, 1, 0};
    vecs[10] = '{7'b1111111, 1, 7, 1, 0};
    vecs[11] = '{7'b1111001, 1, 3, 0, 0};

    pins_al = ~7'b0110000;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_code", int'(code), 0);
    check("rst_valid", int'(code_valid), 0);
    check("rst_err", int'(code_err), 0);
    check("rst_default", int'(is_default), 0);
    check("rst_busy", int'(busy), 0);

    // Latency: pattern present before edge 1, pulse after edge S+2.
    rst = 0; en = 1; pins = 7'b1101101;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("lat_valid_e%0d", k), int'(code_valid), (k == S + 2) ? 1 : 0);
      check($sformatf("lat_busy_e%0d", k), int'(busy), (k <= S + 2) ? 1 : 0);
      if (k == S + 2) check("lat_code", int'(code), 2);
    end

    // Table-driven pattern sequence, 10 cycles per step.
    for (int v = 0; v < 12; v++) begin
      pins = vecs[v].pattern;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (code_valid) begin
          pulses++;
          check($sformatf("vec%0d_code", v), int'(code), vecs[v].exp_code);
          check($sformatf("vec%0d_err", v), int'(code_err), vecs[v].exp_err);
          check($sformatf("vec%0d_default", v), int'(is_default), vecs[v].exp_def);
        end
      end
      check($sformatf("vec%0d_pulses", v), pulses, vecs[v].pulses);
      check($sformatf("vec%0d_hold_code", v), int'(code), vecs[v].exp_code);
      $display("vec %0d pattern %b pulses %0d code %0d err %0b def %0b",
               v, vecs[v].pattern, pulses, code, code_err, is_default);
    end

    // Glitch on seg_g in the last SETTLE cycle: count restarts, pulse 5 cycles late.
    rst = 1; @(negedge clk);
    rst = 0; en = 1; pins = 7'b1111110;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      check($sformatf("glitch_valid_e%0d", k), int'(code_valid), (k == S + 7) ? 1 : 0);
      if (k == S + 7) check("glitch_code", int'(code), 0);
      if (k == S) pins = 7'b1111111;
      if (k == S + 1) pins = 7'b1111110;
    end
    $display("glitch sequence done, code %0d", code);

    // Drop en mid-SETTLE: no pulse, IDLE on the next edge.
    pins = 7'b0110000;
    repeat (3) @(negedge clk);
    check("endrop_busy_before", int'(busy), 1);
    en = 0;
    @(negedge clk);
    check("endrop_busy", int'(busy), 0);
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      pulses += int'(code_valid);
    end
    check("endrop_pulses", pulses, 0);
    $display("enable drop done, pulses %0d", pulses);

    // Re-enable, then reset while in REPORT.
    en = 1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (code_valid) seen = 1;
    end
    check("rearm_pulse_seen", int'(seen), 1);
    check("rearm_code", int'(code), 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rptrst_code", int'(code), 0);
    check("rptrst_valid", int'(code_valid), 0);
    check("rptrst_err", int'(code_err), 0);
    check("rptrst_default", int'(is_default), 0);
    check("rptrst_busy", int'(busy), 0);
    seen = 0;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      if (code_valid) seen = 1;
    end
    check("rereport_seen", int'(seen), 1);
    check("rereport_code", int'(code), 1);
    $display("reset in REPORT done, re-reported code %0d", code);

    // Active-low instance decodes the inverted "1" pattern.
    repeat (2) @(negedge clk);
    check("al_code", int'(al_code), 1);
    check("al_err", int'(al_err), 0);
    check("al_default", int'(al_default), 0);
    check("al_pulse_seen", int'(al_pulses > 0), 1);
    $display("active-low code %0d err %0b pulses %0d", al_code, al_err, al_pulses);

    // Randomized stimulus, checked by the per-cycle model comparison.
    hold_left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold_left == 0) begin
        int r;
        r = $urandom_range(0, 7);
        pins = (r < 5) ? legal[r] : 7'($urandom);
        hold_left = $urandom_range(1, 9);
      end
      hold_left--;
      if ($urandom_range(0, 29) == 0) en = ~en;
      rst = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rst = 0;
    @(negedge clk);
    $display("random phase done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
